// File: rtl/demux_32_bit_1_2_buffered.sv
// 1-to-2 word distributor with a small FIFO per destination lane and
// per-lane delivered-word counters. in_ready depends only on registered occupancy.
module demux_32_bit_1_2_buffered #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [PtrW-1:0]  head_q [2];
  logic [PtrW-1:0]  head_d [2];
  logic [PtrW-1:0]  tail_q [2];
  logic [PtrW-1:0]  tail_d [2];
  logic [OccW-1:0]  occ_q  [2];
  logic [OccW-1:0]  occ_d  [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];

  logic [1:0] lane_valid;
  logic [1:0] lane_full;
  logic [1:0] lane_ready;
  logic [1:0] push;
  logic [1:0] pop;

  assign lane_ready = {out1_ready, out0_ready};

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      lane_valid[l] = occ_q[l] != '0;
      lane_full[l]  = occ_q[l] == OccFull;
    end
  end

  // A full lane refuses even if it pops this cycle: keeps ready free of out*_ready.
  assign in_ready = ~lane_full[in_select];

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      push[l]   = in_valid & in_ready & (in_select == 1'(l));
      pop[l]    = lane_valid[l] & lane_ready[l];
      head_d[l] = head_q[l];
      tail_d[l] = tail_q[l];
      occ_d[l]  = occ_q[l];
      cnt_d[l]  = cnt_q[l];
      if (push[l]) begin
        tail_d[l] = tail_q[l] + 1'b1;
      end
      if (pop[l]) begin
        head_d[l] = head_q[l] + 1'b1;
        cnt_d[l]  = cnt_q[l] + CNT_W'(1);
      end
      unique case ({push[l], pop[l]})
        2'b10:   occ_d[l] = occ_q[l] + OccW'(1);
        2'b01:   occ_d[l] = occ_q[l] - OccW'(1);
        default: occ_d[l] = occ_q[l];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        head_q[l] <= '0;
        tail_q[l] <= '0;
        occ_q[l]  <= '0;
        cnt_q[l]  <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        head_q[l] <= head_d[l];
        tail_q[l] <= tail_d[l];
        occ_q[l]  <= occ_d[l];
        cnt_q[l]  <= cnt_d[l];
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (push[l]) begin
        mem_q[l][tail_q[l]] <= in_data;
      end
    end
  end

  assign out0_valid = lane_valid[0];
  assign out1_valid = lane_valid[1];
  assign out0_data  = lane_valid[0] ? mem_q[0][head_q[0]] : '0;
  assign out1_data  = lane_valid[1] ? mem_q[1][head_q[1]] : '0;
  assign count0     = cnt_q[0];
  assign count1     = cnt_q[1];

endmodule

// File: tb/tb_demux_32_bit_1_2_buffered.sv
// Scoreboard bench for demux_32_bit_1_2_buffered: the driver queues expected words
// per lane on accept; a negedge monitor checks heads, valids, counts and in_ready.
module tb_demux_32_bit_1_2_buffered;

  localparam int Depth = 2;
  localparam int CntW  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     in_data = '0;
  logic            in_select = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     out0_data;
  logic            out0_valid;
  logic            out0_ready = 1'b0;
  logic [31:0]     out1_data;
  logic            out1_valid;
  logic            out1_ready = 1'b0;
  logic [CntW-1:0] count0;
  logic [CntW-1:0] count1;

  int checks = 0;
  int errors = 0;

  logic [31:0]     q0[$];
  logic [31:0]     q1[$];
  logic [CntW-1:0] cnt0 = '0;
  logic [CntW-1:0] cnt1 = '0;

  demux_32_bit_1_2_buffered #(
    .WIDTH(32),
    .DEPTH(Depth),
    .CNT_W(CntW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_select (in_select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .count0    (count0),
    .count1    (count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare what the DUT presents against the model, then retire pops.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out0_valid", out0_valid, q0.size() != 0);
      if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
      else chk("out0_data_empty", out0_data, 0);
      chk("out1_valid", out1_valid, q1.size() != 0);
      if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
      else chk("out1_data_empty", out1_data, 0);
      chk("count0", count0, cnt0);
      chk("count1", count1, cnt1);
      chk("in_ready", in_ready, (in_select ? q1.size() : q0.size()) < Depth);
      if (out0_valid && out0_ready && q0.size() != 0) begin
        void'(q0.pop_front());
        cnt0 = cnt0 + 1'b1;
      end
      if (out1_valid && out1_ready && q1.size() != 0) begin
        void'(q1.pop_front());
        cnt1 = cnt1 + 1'b1;
      end
    end
  end

  // Called at posedge+1; returns with inputs idle at posedge+1.
  task automatic push_word(input logic [31:0] d, input logic s, input int max_wait,
                           output int waits, output bit acc);
    bit ok;
    in_data   = d;
    in_select = s;
    in_valid  = 1'b1;
    waits     = 0;
    acc       = 1'b0;
    while (!acc && waits < max_wait) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) begin
        acc = 1'b1;
        if (s) q1.push_back(d);
        else q0.push_back(d);
      end else begin
        waits++;
      end
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_ok(input logic [31:0] d, input logic s);
    int  w;
    bit  a;
    push_word(d, s, 20, w, a);
    chk("push_accepted", a, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    q0.delete();
    q1.delete();
    cnt0 = '0;
    cnt1 = '0;
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle_state(input string tag);
    @(negedge clk);
    chk({tag, "_valid0"}, out0_valid, 1'b0);
    chk({tag, "_valid1"}, out1_valid, 1'b0);
    chk({tag, "_data0"}, out0_data, 0);
    chk({tag, "_data1"}, out1_data, 0);
    chk({tag, "_count0"}, count0, 0);
    chk({tag, "_count1"}, count1, 0);
    in_select = 1'b0;
    #1;
    chk({tag, "_ready_sel0"}, in_ready, 1'b1);
    in_select = 1'b1;
    #1;
    chk({tag, "_ready_sel1"}, in_ready, 1'b1);
    in_select = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    bit a;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle_state("reset");

    // Basic routing
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    push_ok(32'hDEAD_BEEF, 1'b0);
    push_ok(32'h1234_5678, 1'b1);
    idle(3);
    @(negedge clk);
    chk("basic_count0", count0, 1);
    chk("basic_count1", count1, 1);
    @(posedge clk);
    #1;

    // Lane-full backpressure isolation
    do_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    push_ok(32'h1, 1'b0);
    push_ok(32'h2, 1'b0);
    push_word(32'h3, 1'b0, 3, w, a);
    chk("lane0_full_stall", a, 1'b0);
    push_word(32'hA, 1'b1, 2, w, a);
    chk("lane1_while_lane0_full", a, 1'b1);
    chk("lane1_no_wait", w, 0);
    idle(2);
    out0_ready = 1'b1;
    push_word(32'h3, 1'b0, 10, w, a);
    chk("lane0_accept_after_drain", a, 1'b1);
    idle(4);
    @(negedge clk);
    chk("bp_count0", count0, 3);
    chk("bp_count1", count1, 1);
    @(posedge clk);
    #1;

    // Full with same-cycle pop
    do_reset();
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    push_ok(32'hB, 1'b1);
    push_ok(32'hC, 1'b1);
    out1_ready = 1'b1;
    push_word(32'hD, 1'b1, 5, w, a);
    chk("full_pop_accept", a, 1'b1);
    chk("full_pop_one_stall", w, 1);
    idle(4);
    @(negedge clk);
    chk("full_pop_count1", count1, 3);
    @(posedge clk);
    #1;

    // Counter wrap at CNT_W=4
    do_reset();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_ok(32'h100 + i, 1'b0);
    idle(3);
    @(negedge clk);
    chk("wrap_count0", count0, 1);
    chk("wrap_count1", count1, 0);
    @(posedge clk);
    #1;

    // Reset mid-operation
    do_reset();
    push_ok(32'h31, 1'b0);
    push_ok(32'h41, 1'b1);
    idle(2);
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    push_ok(32'h11, 1'b0);
    push_ok(32'h12, 1'b0);
    push_ok(32'h21, 1'b1);
    push_ok(32'h22, 1'b1);
    @(negedge clk);
    chk("pre_reset_count0", count0, 1);
    chk("pre_reset_valid1", out1_valid, 1'b1);
    @(posedge clk);
    #1;
    do_reset();
    check_idle_state("midreset");
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    idle(4);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
